serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Parametrised multi-cycle adder/subtractor: latches two WIDTH-bit operands on start, then adds DIGIT bits per clock
//   through a registered carry, LSB first. Flags completion with a one-cycle done pulse.
//   Successor to the team's 1-bit complete adder; the arithmetic core for the datapath exercises that follow.
// PARAMETERS
//   WIDTH  8  operand/result width in bits, >= 2
//   DIGIT  1  bits processed per clock; WIDTH % DIGIT == 0; STEPS = WIDTH/DIGIT
// PORTS
//   clk       in   1      single clock, rising edge
//   reset     in   1      synchronous, active-high reset
//   start     in   1      request; sampled only in IDLE
//   sub       in   1      0: a+b+c_in   1: a-b (c_in ignored)
//   c_in      in   1      carry-in for add mode
//   a         in   WIDTH  operand A, sampled with start
//   b         in   WIDTH  operand B, sampled with start
//   busy      out  1      high while an operation is in RUN
//   done      out  1      one-cycle pulse: result valid
//   s         out  WIDTH  sum/difference, held until next completion
//   c_out     out  1      carry out; in sub mode 1 = no borrow
//   overflow  out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset: state IDLE; busy, done, s, c_out, overflow, step counter, internal regs all 0. Reset beats start.
//   - FSM IDLE -> RUN on start. RUN -> IDLE after step STEPS-1. No other states.
//   - Accept, at edge k in IDLE with start=1:
//       - latch A = a and B = sub ? ~b : b
//       - carry = sub ? 1 : c_in
//       - count = 0
//       - busy = 1
//   - RUN edge:
//       - add A[DIGIT-1:0] + B[DIGIT-1:0] + carry
//       - update carry
//       - shift A and B right by DIGIT
//       - shift the DIGIT result bits into the internal sum reg from the MSB end
//       - count++
//   - Final step, edge k+STEPS:
//       - load s, c_out and overflow
//       - done = 1 for exactly one cycle
//       - busy = 0
//       - state IDLE
//   - Latency: done visible STEPS cycles after the accepting edge; DIGIT=WIDTH gives 1 cycle.
//   - Back-to-back: start may be asserted in the done cycle. It is accepted, and done drops next cycle.
//   - start while busy is ignored; no queuing. a, b, sub and c_in are don't-care outside the accept edge.
//   - s, c_out, overflow change only on a completion edge or reset; stable otherwise.
//   - Reset mid-RUN aborts: no done; outputs return to 0.
//   - All arithmetic is modulo 2^WIDTH; overflow is taken from the carries of the final step's MSB.
// STRUCTURE
//   - Shared package sa_pkg: state encoding localparams (ST_IDLE, ST_RUN).
//   - Shared package sa_pkg: function clog2 for the counter width.
//   - Sub-module serial_adder_slice: combinational DIGIT-bit ripple of 1-bit full adders.
//       - inputs: x, y, ci
//       - outputs: s, co, c_msb (carry into top bit)
//   - Top: FSM, counter, operand/sum shift registers, output registers.
// TESTING
//   1. W8 D1, add 0x5A+0x3C c_in=0 -> s=0x96, c_out=0, overflow=1; done exactly 8 cycles after start, 1 cycle wide.
//   2. W8 D1, add 0xFF+0x01 c_in=1 -> s=0x01, c_out=1, overflow=0. Then sub 0x10-0x20 -> s=0xF0, c_out=0, overflow=0.
//   3. W8 D4, sub 0x80-0x01 -> s=0x7F, c_out=1, overflow=1; done 2 cycles after start.
//   4. Start pulsed mid-RUN with other operands -> ignored, first result intact. Start in done cycle -> second result correct.
//   5. Reset at step 3 of 8 -> no done; s/c_out/overflow/busy=0. A following start completes normally.
//   6. W4 D1 and W4 D2: exhaustive a, b, c_in, sub vs behavioural model; s, c_out, overflow match; outputs stable between dones.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the serial adder: FSM state type and a constant
// ceil(log2) helper used to size the step counter.
package sa_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sa_state_t;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_slice.sv
// DIGIT-bit combinational ripple of 1-bit full adders. Also exposes the
// carry into the top bit so the caller can derive signed overflow.
module serial_adder_slice #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] carry;

    // Ripple the carry through DIGIT full-adder cells, LSB first.
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = ci;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            s[i]       = x[i] ^ y[i] ^ carry[i];
            carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
        end
        co    = carry[DIGIT];
        c_msb = carry[DIGIT-1];
    end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: latches operands on start, then processes
// DIGIT bits per clock LSB first through a registered carry. Results are
// registered and flagged with a one-cycle done pulse.
module serial_adder
    import sa_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (clog2(STEPS) > 0) ? clog2(STEPS) : 1;
    localparam int unsigned LAST  = STEPS - 1;

    sa_state_t          state_q;
    sa_state_t          state_d;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   sum_next;
    logic               carry_q;
    logic [DIGIT-1:0]   slice_s;
    logic               slice_co;
    logic               slice_msb;
    logic               last_step;

    assign last_step = (count_q == CNT_W'(LAST));
    assign busy      = (state_q == ST_RUN);

    serial_adder_slice #(
        .DIGIT(DIGIT)
    ) u_slice (
        .x     (a_q[DIGIT-1:0]),
        .y     (b_q[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (slice_s),
        .co    (slice_co),
        .c_msb (slice_msb)
    );

    // New result digits enter from the MSB end; a single-step build has no
    // older digits to keep, so that case is split out to avoid an empty slice.
    generate
        if (DIGIT == WIDTH) begin : g_one_step
            assign sum_next = slice_s;
        end else begin : g_multi_step
            assign sum_next = {slice_s, sum_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE -> RUN on start, RUN -> IDLE after the final step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_RUN;
            ST_RUN:  if (last_step) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Operand latch, per-step shift/accumulate and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            done     <= 1'b0;
            s        <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : c_in;
                        count_q <= '0;
                    end
                end
                ST_RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= slice_co;
                    sum_q   <= sum_next;
                    count_q <= count_q + 1'b1;
                    if (last_step) begin
                        s        <= sum_next;
                        c_out    <= slice_co;
                        overflow <= slice_co ^ slice_msb;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: four instances (W8/D1, W8/D4, W4/D1,
// W4/D2) compared against an integer-arithmetic reference model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       sub_in;
    logic       cin_in;
    logic [3:0] start_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] co_v;
    logic [3:0] ov_v;
    logic [7:0] s_w8d1;
    logic [7:0] s_w8d4;
    logic [3:0] s_w4d1;
    logic [3:0] s_w4d2;

    int n_pass  = 0;
    int n_total = 0;

    int width_of [4] = '{8, 8, 4, 4};
    int steps_of [4] = '{8, 2, 4, 2};

    logic [7:0] last_s [4];
    logic       last_c [4];
    logic       last_v [4];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .sub(sub_in), .c_in(cin_in),
        .a(a_in), .b(b_in), .busy(busy_v[0]), .done(done_v[0]), .s(s_w8d1),
        .c_out(co_v[0]), .overflow(ov_v[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .reset(reset), .start(start_v[1]), .sub(sub_in), .c_in(cin_in),
        .a(a_in), .b(b_in), .busy(busy_v[1]), .done(done_v[1]), .s(s_w8d4),
        .c_out(co_v[1]), .overflow(ov_v[1])
    );

    serial_adder #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
        .clk(clk), .reset(reset), .start(start_v[2]), .sub(sub_in), .c_in(cin_in),
        .a(a_in[3:0]), .b(b_in[3:0]), .busy(busy_v[2]), .done(done_v[2]), .s(s_w4d1),
        .c_out(co_v[2]), .overflow(ov_v[2])
    );

    serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .reset(reset), .start(start_v[3]), .sub(sub_in), .c_in(cin_in),
        .a(a_in[3:0]), .b(b_in[3:0]), .busy(busy_v[3]), .done(done_v[3]), .s(s_w4d2),
        .c_out(co_v[3]), .overflow(ov_v[3])
    );

    function automatic logic [7:0] s_of(input int idx);
        case (idx)
            0:       return s_w8d1;
            1:       return s_w8d4;
            2:       return {4'h0, s_w4d1};
            default: return {4'h0, s_w4d2};
        endcase
    endfunction

    // Reference: plain integer add/subtract with signed range test for overflow.
    function automatic void model(input int w, input int av, input int bv,
                                  input bit sv, input bit cv,
                                  output int es, output bit ec, output bit ev);
        int mask;
        int half;
        int sa;
        int sb;
        int r;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        sa   = (av >= half) ? av - (1 << w) : av;
        sb   = (bv >= half) ? bv - (1 << w) : bv;
        if (!sv) begin
            es = (av + bv + int'(cv)) & mask;
            ec = ((av + bv + int'(cv)) >> w) != 0;
            r  = sa + sb + int'(cv);
        end else begin
            es = (av - bv) & mask;
            ec = (av >= bv);
            r  = sa - sb;
        end
        ev = (r > half - 1) || (r < -half);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_last();
        for (int i = 0; i < 4; i++) begin
            last_s[i] = '0;
            last_c[i] = 1'b0;
            last_v[i] = 1'b0;
        end
    endtask

    // Drive operands with start for one edge; return 1ns after the accepting edge.
    task automatic launch(input int idx, input int av, input int bv, input bit sv, input bit cv);
        a_in         = av[7:0];
        b_in         = bv[7:0];
        sub_in       = sv;
        cin_in       = cv;
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
        a_in         = 8'($urandom);
        b_in         = 8'($urandom);
        sub_in       = 1'($urandom);
        cin_in       = 1'($urandom);
        check("busy_after_accept", 32'(busy_v[idx]), 32'd1);
        check("done_after_accept", 32'(done_v[idx]), 32'd0);
    endtask

    // Wait (bounded) for done, checking held outputs meanwhile, then compare results.
    task automatic finish_op(input int idx, input int av, input int bv,
                             input bit sv, input bit cv, input bit inject);
        int es;
        bit ec;
        bit ev;
        int n;
        model(width_of[idx], av, bv, sv, cv, es, ec, ev);
        n = 0;
        while (done_v[idx] !== 1'b1 && n < steps_of[idx] + 4) begin
            check("stable_s", 32'(s_of(idx)), 32'(last_s[idx]));
            check("stable_c_out", 32'(co_v[idx]), 32'(last_c[idx]));
            check("stable_overflow", 32'(ov_v[idx]), 32'(last_v[idx]));
            if (inject && n == 2) begin
                a_in         = 8'($urandom);
                b_in         = 8'($urandom);
                sub_in       = ~sv;
                start_v[idx] = 1'b1;
            end
            if (n == 3) start_v[idx] = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        start_v[idx] = 1'b0;
        check("done_seen", 32'(done_v[idx]), 32'd1);
        check("latency", 32'(n), 32'(steps_of[idx]));
        check("result_s", 32'(s_of(idx)), 32'(es));
        check("result_c_out", 32'(co_v[idx]), 32'(ec));
        check("result_overflow", 32'(ov_v[idx]), 32'(ev));
        check("busy_in_done", 32'(busy_v[idx]), 32'd0);
        last_s[idx] = 8'(es);
        last_c[idx] = ec;
        last_v[idx] = ev;
    endtask

    task automatic do_op(input int idx, input int av, input int bv, input bit sv, input bit cv);
        launch(idx, av, bv, sv, cv);
        finish_op(idx, av, bv, sv, cv, 1'b0);
    endtask

    task automatic idle_cycle(input int idx);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done_v[idx]), 32'd0);
        check("idle_busy", 32'(busy_v[idx]), 32'd0);
        check("idle_s_held", 32'(s_of(idx)), 32'(last_s[idx]));
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy"}, 32'(busy_v[i]), 32'd0);
            check({tag, "_done"}, 32'(done_v[i]), 32'd0);
            check({tag, "_s"}, 32'(s_of(i)), 32'd0);
            check({tag, "_c_out"}, 32'(co_v[i]), 32'd0);
            check({tag, "_overflow"}, 32'(ov_v[i]), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        start_v = '0;
        a_in    = '0;
        b_in    = '0;
        sub_in  = 1'b0;
        cin_in  = 1'b0;
        clear_last();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");

        // Reset beats start.
        start_v = '1;
        @(posedge clk);
        #1;
        check_all_zero("reset_vs_start");
        start_v = '0;
        reset   = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("after_reset");

        // Directed: W8 D1 add with overflow.
        do_op(0, 'h5A, 'h3C, 1'b0, 1'b0);
        check("t1_s", 32'(s_w8d1), 32'h96);
        check("t1_c_out", 32'(co_v[0]), 32'd0);
        check("t1_overflow", 32'(ov_v[0]), 32'd1);
        idle_cycle(0);

        // Directed: wrap with carry-in, then subtract with borrow.
        do_op(0, 'hFF, 'h01, 1'b0, 1'b1);
        check("t2a_s", 32'(s_w8d1), 32'h01);
        check("t2a_c_out", 32'(co_v[0]), 32'd1);
        check("t2a_overflow", 32'(ov_v[0]), 32'd0);
        idle_cycle(0);
        do_op(0, 'h10, 'h20, 1'b1, 1'b0);
        check("t2b_s", 32'(s_w8d1), 32'hF0);
        check("t2b_c_out", 32'(co_v[0]), 32'd0);
        check("t2b_overflow", 32'(ov_v[0]), 32'd0);
        idle_cycle(0);

        // Directed: W8 D4 subtract with signed overflow, two-cycle latency.
        do_op(1, 'h80, 'h01, 1'b1, 1'b0);
        check("t3_s", 32'(s_w8d4), 32'h7F);
        check("t3_c_out", 32'(co_v[1]), 32'd1);
        check("t3_overflow", 32'(ov_v[1]), 32'd1);
        idle_cycle(1);

        // Start mid-run ignored; then start in the done cycle.
        launch(0, 'h12, 'h34, 1'b0, 1'b0);
        finish_op(0, 'h12, 'h34, 1'b0, 1'b0, 1'b1);
        check("t4_first_s", 32'(s_w8d1), 32'h46);
        launch(0, 'hC8, 'h64, 1'b1, 1'b1);
        finish_op(0, 'hC8, 'h64, 1'b1, 1'b1, 1'b0);
        check("t4_second_s", 32'(s_w8d1), 32'h64);
        idle_cycle(0);

        // Reset at step 3 of 8 aborts without done.
        launch(0, 'hA5, 'h5A, 1'b0, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("t5_no_done_pre", 32'(done_v[0]), 32'd0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_last();
        check_all_zero("t5_abort");
        repeat (10) begin
            @(posedge clk);
            #1;
            check("t5_no_done_post", 32'(done_v[0]), 32'd0);
        end
        do_op(0, 'h3F, 'h41, 1'b0, 1'b0);
        idle_cycle(0);

        // Randomized W8 operations, mixing back-to-back and idle gaps.
        for (int i = 0; i < 150; i++) begin
            int idx;
            idx = int'($urandom_range(0, 1));
            do_op(idx, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle_cycle(idx);
        end

        // Exhaustive W4 operations for both digit sizes.
        for (int idx = 2; idx < 4; idx++) begin
            for (int av = 0; av < 16; av++) begin
                for (int bv = 0; bv < 16; bv++) begin
                    for (int m = 0; m < 4; m++) begin
                        do_op(idx, av, bv, m[1], m[0]);
                    end
                end
            end
            idle_cycle(idx);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
